// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the pipelined FPU barrel shifter.
//   shift_mode_e : operation encoding carried down the pipe
//   SWR_DEF      : default data width (implicit bit + significand + guard + round)
//   EWR_DEF      : default shift-amount width, which is also the number of levels
package fpu_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,   // logical left, vacated bits take the fill bit
        MODE_LSR = 2'b01,   // logical right, vacated bits take the fill bit
        MODE_ASR = 2'b10,   // arithmetic right, vacated bits take the operand MSB
        MODE_ROR = 2'b11    // rotate right
    } shift_mode_e;

    localparam int SWR_DEF = 26;
    localparam int EWR_DEF = 5;

endpackage

// File: rtl/shift_level.sv
// One combinational level of the barrel shifter: shifts or rotates by 2^LVL
// when en_i is set, otherwise passes the data through.
//   data_i / data_o : operand in, shifted operand out
//   mode_i          : shift_mode_e encoding
//   fill_i          : fill bit for the logical modes
//   en_i            : this level's shift-amount bit
//   sticky_o        : OR of the bits dropped by this level (right shifts only)
module shift_level
    import fpu_shift_pkg::*;
#(
    parameter int SWR = SWR_DEF,
    parameter int LVL = 0
) (
    input  logic [SWR-1:0] data_i,
    input  logic [1:0]     mode_i,
    input  logic           fill_i,
    input  logic           en_i,
    output logic [SWR-1:0] data_o,
    output logic           sticky_o
);

    localparam int SH  = 1 << LVL;
    // Rotating by 2^LVL mod SWR at each level sums to (amount mod SWR).
    localparam int ROT = SH % SWR;

    logic           fill_r;
    logic [SWR-1:0] lsl_d;
    logic [SWR-1:0] rsh_d;
    logic [SWR-1:0] ror_d;
    logic           rsh_lost;

    // The MSB never changes through arithmetic levels, so the current MSB
    // is always the original operand sign.
    assign fill_r = (mode_i == MODE_ASR) ? data_i[SWR-1] : fill_i;

    generate
        if (SH >= SWR) begin : g_full
            // Step at least as wide as the word: everything falls off.
            assign lsl_d    = {SWR{fill_i}};
            assign rsh_d    = {SWR{fill_r}};
            assign rsh_lost = |data_i;
        end else begin : g_part
            assign lsl_d    = {data_i[SWR-1-SH:0], {SH{fill_i}}};
            assign rsh_d    = {{SH{fill_r}}, data_i[SWR-1:SH]};
            assign rsh_lost = |data_i[SH-1:0];
        end

        if (ROT == 0) begin : g_rot_id
            assign ror_d = data_i;
        end else begin : g_rot
            assign ror_d = {data_i[ROT-1:0], data_i[SWR-1:ROT]};
        end
    endgenerate

    always_comb begin
        data_o   = data_i;
        sticky_o = 1'b0;
        if (en_i) begin
            case (mode_i)
                MODE_LSL: data_o = lsl_d;
                MODE_LSR,
                MODE_ASR: begin
                    data_o   = rsh_d;
                    sticky_o = rsh_lost;
                end
                default:  data_o = ror_d;
            endcase
        end
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: input register S0 followed by EWR level
// registers, one power-of-two step per level. All stages advance together
// on adv = !out_valid_o | out_ready_i, so a stalled output freezes the pipe.
//   clk, rst (async, active low), flush_i (sync clear of valid bits)
//   in_valid_i / in_ready_o / shift_data_i / shift_value_i / mode_i / bit_shift_i
//   out_valid_o / out_ready_i / n_mant_o / sticky_o / zero_o
module pipe_barrel_shifter
    import fpu_shift_pkg::*;
#(
    parameter int SWR = SWR_DEF,
    parameter int EWR = EWR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [SWR-1:0] shift_data_i,
    input  logic [EWR-1:0] shift_value_i,
    input  logic [1:0]     mode_i,
    input  logic           bit_shift_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [SWR-1:0] n_mant_o,
    output logic           sticky_o,
    output logic           zero_o
);

    // Stage k holds the operand after levels 0..k-1 have been applied.
    logic [EWR:0]              vld_pipe;
    logic [EWR:0][SWR-1:0]     data_q;
    logic [EWR:0]              sticky_q;
    // Control only needed up to the last level's input.
    logic [EWR-1:0][1:0]       mode_q;
    logic [EWR-1:0]            fill_q;
    // Amount is pre-shifted so bit 0 is always the current level's bit.
    logic [EWR-1:0][EWR-1:0]   amt_q;

    logic [EWR-1:0][SWR-1:0]   lvl_data;
    logic [EWR-1:0]            lvl_sticky;
    logic [EWR-1:0]            lvl_en;
    logic                      adv;

    assign adv         = !vld_pipe[EWR] | out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = vld_pipe[EWR];
    assign n_mant_o    = data_q[EWR];
    assign sticky_o    = sticky_q[EWR];
    assign zero_o      = (data_q[EWR] == '0);

    generate
        for (genvar i = 0; i < EWR; i++) begin : g_lvl
            if (i == EWR - 1) begin : g_last
                // Only bit 0 can be set here; the OR just consumes the
                // zero upper bits.
                assign lvl_en[i] = |amt_q[i];
            end else begin : g_mid
                assign lvl_en[i] = amt_q[i][0];
            end

            shift_level #(
                .SWR (SWR),
                .LVL (i)
            ) u_lvl (
                .data_i   (data_q[i]),
                .mode_i   (mode_q[i]),
                .fill_i   (fill_q[i]),
                .en_i     (lvl_en[i]),
                .data_o   (lvl_data[i]),
                .sticky_o (lvl_sticky[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            data_q   <= '0;
            sticky_q <= '0;
            mode_q   <= '0;
            fill_q   <= '0;
            amt_q    <= '0;
        end else if (flush_i) begin
            // Data registers keep their contents; only validity is dropped.
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[EWR-1:0], in_valid_i};

            // Data moves only behind a valid beat to avoid needless toggling.
            if (in_valid_i) begin
                data_q[0]   <= shift_data_i;
                sticky_q[0] <= 1'b0;
                mode_q[0]   <= mode_i;
                fill_q[0]   <= bit_shift_i;
                amt_q[0]    <= shift_value_i;
            end

            for (int k = 0; k < EWR; k++) begin
                if (vld_pipe[k]) begin
                    data_q[k+1]   <= lvl_data[k];
                    sticky_q[k+1] <= sticky_q[k] | lvl_sticky[k];
                end
            end

            for (int k = 0; k < EWR - 1; k++) begin
                if (vld_pipe[k]) begin
                    mode_q[k+1] <= mode_q[k];
                    fill_q[k+1] <= fill_q[k];
                    amt_q[k+1]  <= amt_q[k] >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
module tb_pipe_barrel_shifter;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [25:0] shift_data_i;
    logic [4:0]  shift_value_i;
    logic [1:0]  mode_i;
    logic        bit_shift_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [25:0] n_mant_o;
    logic        sticky_o;
    logic        zero_o;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_barrel_shifter #(.SWR(26), .EWR(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .shift_data_i  (shift_data_i),
        .shift_value_i (shift_value_i),
        .mode_i        (mode_i),
        .bit_shift_i   (bit_shift_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .n_mant_o      (n_mant_o),
        .sticky_o      (sticky_o),
        .zero_o        (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [25:0] d, input logic [4:0] a,
                         input logic [1:0] m, input logic f);
        shift_data_i  = d;
        shift_value_i = a;
        mode_i        = m;
        bit_shift_i   = f;
    endtask

    // Offer one beat into an empty pipe, then check latency and result.
    task automatic send_one(input string tag, input logic [25:0] d, input logic [4:0] a,
                            input logic [1:0] m, input logic f,
                            input logic [25:0] ed, input logic es, input logic ez);
        int cnt;
        @(negedge clk);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        drive(d, a, m, f);
        @(negedge clk);
        in_valid_i = 1'b0;
        cnt = 1;
        while (!out_valid_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lat"},    cnt,      32'd6);
        chk({tag, "_mant"},   n_mant_o, {6'd0, ed});
        chk({tag, "_sticky"}, sticky_o, {31'd0, es});
        chk({tag, "_zero"},   zero_o,   {31'd0, ez});
    endtask

    logic [25:0] exp_q [$];
    logic [25:0] held;
    int sent, rcv, stale, ready_lo;

    initial begin
        rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        drive(26'd0, 5'd0, 2'b00, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid",  out_valid_o, 32'd0);
        chk("rst_mant",   n_mant_o,    32'd0);
        chk("rst_sticky", sticky_o,    32'd0);
        chk("rst_zero",   zero_o,      32'd1);
        chk("rst_ready",  in_ready_o,  32'd1);
        rst = 1'b1;

        // Directed single beats (first one accepted on the first edge after reset)
        send_one("lsr1",  26'h2000001, 5'd1,  2'b01, 1'b0, 26'h1000000, 1'b1, 1'b0);
        send_one("lsl3",  26'h0000001, 5'd3,  2'b00, 1'b1, 26'h000000F, 1'b0, 1'b0);
        send_one("asr4",  26'h2000000, 5'd4,  2'b10, 1'b0, 26'h3E00000, 1'b0, 1'b0);
        send_one("ror27", 26'h0000001, 5'd27, 2'b11, 1'b0, 26'h2000000, 1'b0, 1'b0);
        send_one("lsr31", 26'h3FFFFFF, 5'd31, 2'b01, 1'b0, 26'h0000000, 1'b1, 1'b1);
        send_one("asr30", 26'h2000000, 5'd30, 2'b10, 1'b0, 26'h3FFFFFF, 1'b1, 1'b0);
        send_one("lsl26", 26'h0000003, 5'd26, 2'b00, 1'b0, 26'h0000000, 1'b0, 1'b1);
        send_one("lsr0",  26'h155AAAA, 5'd0,  2'b01, 1'b1, 26'h155AAAA, 1'b0, 1'b0);
        send_one("ror1",  26'h0000003, 5'd1,  2'b11, 1'b0, 26'h2000001, 1'b0, 1'b0);
        send_one("lsr2f", 26'h0000004, 5'd2,  2'b01, 1'b1, 26'h3000001, 1'b0, 1'b0);

        // Back-to-back stream with a 3-cycle downstream stall
        sent = 0; rcv = 0; ready_lo = 0;
        for (int k = 0; k < 10; k++) exp_q.push_back((26'h100 + 26'(k)) << 4);
        for (int c = 0; c < 80 && rcv < 10; c++) begin
            @(negedge clk);
            out_ready_i = !(c >= 10 && c < 13);
            in_valid_i  = (sent < 10);
            drive(26'h100 + 26'(sent), 5'd4, 2'b00, 1'b0);
            #1;
            if (c == 10) held = n_mant_o;
            if (c >= 10 && c < 13) begin
                chk("b2b_stall_ready", in_ready_o, 32'd0);
                if (c > 10) chk("b2b_hold", n_mant_o, {6'd0, held});
            end
            if (in_valid_i && in_ready_o) sent++;
            if (out_valid_o && out_ready_i) begin
                chk($sformatf("b2b_beat%0d", rcv), n_mant_o, {6'd0, exp_q.pop_front()});
                rcv++;
            end
        end
        in_valid_i = 1'b0;
        chk("b2b_count", rcv, 32'd10);
        repeat (3) @(negedge clk);
        chk("b2b_drained", out_valid_o, 32'd0);

        // Reset with 4 beats in flight
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid_i = 1'b1;
            drive(26'h0000010 + 26'(k), 5'd1, 2'b00, 1'b0);
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstm_pre_valid", out_valid_o, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstm_valid", out_valid_o, 32'd0);
        chk("rstm_mant",  n_mant_o,    32'd0);
        chk("rstm_zero",  zero_o,      32'd1);
        chk("rstm_ready", in_ready_o,  32'd1);
        @(negedge clk);
        rst = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            stale += int'(out_valid_o);
        end
        chk("rstm_stale", stale, 32'd0);

        // Flush with 3 beats in flight, plus a beat offered during the flush
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid_i = 1'b1;
            drive(26'h0000020 + 26'(k), 5'd2, 2'b01, 1'b0);
        end
        @(negedge clk);
        flush_i = 1'b1;
        drive(26'h0000001, 5'd0, 2'b00, 1'b0);
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_valid", out_valid_o, 32'd0);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            stale += int'(out_valid_o);
        end
        chk("flush_stale", stale, 32'd0);
        send_one("post_flush", 26'h0000100, 5'd8, 2'b01, 1'b0, 26'h0000001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
